// File: rtl/lcd_pkg.sv
// Shared types, field positions and init table for the LCD command controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  // Bit positions of the fields inside the 32-bit LCD command word.
  localparam int unsigned ON_BIT   = 31;
  localparam int unsigned RS_BIT   = 9;
  localparam int unsigned DATA_MSB = 7;

  // Power-up command sequence: 8-bit/2 lines, display on, clear, entry increment.
  localparam logic [2:0] INIT_LEN = 3'd4;
  localparam logic [7:0] LCD_INIT [0:3] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter that stops at zero; zero_o flags expiry of a delay.
// No reset of its own: the controller holds load_i during reset with the power-up delay.
module lcd_delay_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD controller: power-up wait, fixed init sequence, then
// replays one accepted command word per handshake with setup/pulse/hold/exec timing.
// All T_* parameters must be at least 1.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 1850,
  parameter int unsigned T_EXEC_LONG = 76000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  output logic        cmd_ready_o,
  output logic        init_done_o,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o
);

  localparam int unsigned T_MAX_A = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int unsigned T_MAX_B = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
  localparam int unsigned T_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_D > T_MAX_C) ? T_MAX_D : T_MAX_C;
  localparam int unsigned CNT_W   = $clog2(T_MAX) + 1;

  lcd_state_e       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             on_q, on_d;
  logic             en_q, en_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // Only ON, RS and DATA carry meaning; the remaining command bits are ignored.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_i[30:10], cmd_i[8]};

  lcd_delay_cnt #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk_i      (clk_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  // Next-state and next-output logic; every state change reloads the delay counter.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = done_q;
    ready_d  = ready_q;
    on_d     = on_q;
    en_d     = en_q;
    rs_d     = rs_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_zero) begin
          on_d    = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        rs_d     = 1'b0;
        data_d   = LCD_INIT[idx_q[1:0]];
        idx_d    = idx_q + 3'd1;
        state_d  = ST_SETUP;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(T_SETUP - 1);
      end
      ST_IDLE: begin
        if (cmd_valid_i) begin
          rs_d     = cmd_i[RS_BIT];
          data_d   = cmd_i[DATA_MSB:0];
          on_d     = cmd_i[ON_BIT];
          ready_d  = 1'b0;
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          en_d     = 1'b1;
          state_d  = ST_PULSE;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_PULSE - 1);
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          en_d     = 1'b0;
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(T_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d  = ST_EXEC;
          cnt_load = 1'b1;
          cnt_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_EXEC_LONG - 1)
                                               : CNT_W'(T_EXEC - 1);
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          if (idx_q < INIT_LEN) begin
            state_d = ST_INIT;
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_PWRUP;
      end
    endcase
    if (!rst_ni) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(T_POWERUP - 1);
    end
  end

  // State and registered outputs; reset restarts the whole power-up sequence.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_PWRUP;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      on_q    <= on_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign init_done_o = done_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: timeline model plus directed command vectors.
module tb_lcd_ctrl;

  localparam int unsigned TP_PWR   = 5;
  localparam int unsigned TP_SETUP = 1;
  localparam int unsigned TP_PULSE = 2;
  localparam int unsigned TP_HOLD  = 1;
  localparam int unsigned TP_EXEC  = 3;
  localparam int unsigned TP_LONG  = 6;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cmdValid;
  logic [31:0] cmdWord;
  logic        cmdReady;
  logic        initDone;
  logic        lcdOn;
  logic        lcdEn;
  logic        lcdRs;
  logic        lcdRw;
  logic [7:0]  lcdData;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_POWERUP   (TP_PWR),
    .T_SETUP     (TP_SETUP),
    .T_PULSE     (TP_PULSE),
    .T_HOLD      (TP_HOLD),
    .T_EXEC      (TP_EXEC),
    .T_EXEC_LONG (TP_LONG)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .cmd_valid_i (cmdValid),
    .cmd_i       (cmdWord),
    .cmd_ready_o (cmdReady),
    .init_done_o (initDone),
    .lcd_on_o    (lcdOn),
    .lcd_en_o    (lcdEn),
    .lcd_rs_o    (lcdRs),
    .lcd_rw_o    (lcdRw),
    .lcd_data_o  (lcdData)
  );

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Timeline model: each operation starting at edge t fixes its pins and end edge by arithmetic.
  logic [7:0] initRef [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int   cyc = 0;
  bit   modelValid = 1'b0;
  int   pwrEnd = -1, nextLatch = -1, opEnd = -1, enLo = -1, enHi = -2, initIdx = 0;
  logic mReady = 1'b0, mDone = 1'b0, mOn = 1'b0, mEn = 1'b0, mRs = 1'b0;
  logic [7:0] mData = 8'h00;

  function automatic int execTime(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TP_LONG;
    return TP_EXEC;
  endfunction

  function automatic void startOp(input logic rs, input logic [7:0] d, input int t);
    mRs   = rs;
    mData = d;
    enLo  = t + TP_SETUP;
    enHi  = t + TP_SETUP + TP_PULSE - 1;
    opEnd = t + TP_SETUP + TP_PULSE + TP_HOLD + execTime(rs, d);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rstN) begin
      modelValid = 1'b1;
      mReady = 1'b0; mDone = 1'b0; mOn = 1'b0; mEn = 1'b0; mRs = 1'b0; mData = 8'h00;
      pwrEnd = cyc + TP_PWR;
      nextLatch = cyc + TP_PWR + 1;
      opEnd = -1; enLo = -1; enHi = -2; initIdx = 0;
    end else if (modelValid) begin
      if (cyc == pwrEnd) mOn = 1'b1;
      if (cyc == nextLatch) begin
        startOp(1'b0, initRef[initIdx], cyc);
        initIdx++;
        nextLatch = -1;
      end else if (cyc == opEnd) begin
        opEnd = -1;
        if (initIdx < 4) nextLatch = cyc + 1;
        else begin
          mDone  = 1'b1;
          mReady = 1'b1;
        end
      end else if (mReady && cmdValid) begin
        mReady = 1'b0;
        mOn    = cmdWord[31];
        startOp(cmdWord[9], cmdWord[7:0], cyc);
      end
      mEn = (cyc >= enLo) && (cyc <= enHi);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("ready", 32'(cmdReady), 32'(mReady));
      checkOutput("init_done", 32'(initDone), 32'(mDone));
      checkOutput("lcd_on", 32'(lcdOn), 32'(mOn));
      checkOutput("lcd_en", 32'(lcdEn), 32'(mEn));
      checkOutput("lcd_rs", 32'(lcdRs), 32'(mRs));
      checkOutput("lcd_rw", 32'(lcdRw), 32'd0);
      checkOutput("lcd_data", 32'(lcdData), 32'(mData));
    end
  end

  // Records every EN rising sample with the RS/DATA it carried.
  int   sampleIdx = 0;
  logic prevEn = 1'b0;
  int   pulseWord[$];
  int   pulseAt[$];
  always @(negedge clk) begin
    sampleIdx++;
    if (lcdEn === 1'b1 && prevEn !== 1'b1) begin
      pulseWord.push_back(int'({lcdRs, lcdData}));
      pulseAt.push_back(sampleIdx);
    end
    prevEn = lcdEn;
  end

  task automatic waitInitDone(input string name);
    int t = 0;
    while (initDone !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checkOutput({name, "_done"}, 32'(initDone), 32'd1);
    checkOutput({name, "_ready_with_done"}, 32'(cmdReady), 32'd1);
  endtask

  task automatic checkInit(input string name);
    int words [4] = '{32'h038, 32'h00C, 32'h001, 32'h006};
    int gaps  [3] = '{8, 8, 11};
    checkOutput({name, "_pulse_count"}, 32'(pulseWord.size()), 32'd4);
    if (pulseWord.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        checkOutput($sformatf("%s_word%0d", name, i), 32'(pulseWord[i]), 32'(words[i]));
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("%s_gap%0d", name, i), 32'(pulseAt[i+1] - pulseAt[i]), 32'(gaps[i]));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input bit holdValid, input logic [31:0] nextWord,
                               output int waited, output int busy, output int enFirst, output int enWidth);
    waited = 0;
    while (cmdReady !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_send", 32'(cmdReady), 32'd1);
    cmdWord  = word;
    cmdValid = 1'b1;
    @(negedge clk);
    if (!holdValid) cmdValid = 1'b0;
    busy = 0; enFirst = 0; enWidth = 0;
    while (cmdReady !== 1'b1 && busy < 300) begin
      busy++;
      if (lcdEn === 1'b1) begin
        if (enFirst == 0) enFirst = busy;
        enWidth++;
      end
      if (holdValid) cmdWord = $urandom();
      @(negedge clk);
    end
    if (holdValid) cmdWord = nextWord;
  endtask

  typedef struct { logic [31:0] word; int busy; } vec_t;
  vec_t vecs [3] = '{'{32'h0000_0001, 10}, '{32'h0000_0002, 10}, '{32'h0000_0080, 7}};

  initial begin
    int w, b, ef, ew, t;
    rstN = 1'b0; cmdValid = 1'b0; cmdWord = 32'h0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;

    $display("[TB] power-up and init sequence");
    waitInitDone("init1");
    checkInit("init1");

    $display("[TB] data write 0x41");
    pulseWord.delete(); pulseAt.delete();
    applyStimulus(32'h8000_0241, 1'b0, 32'h0, w, b, ef, ew);
    checkOutput("data41_busy", 32'(b), 32'd7);
    checkOutput("data41_en_first", 32'(ef), 32'd2);
    checkOutput("data41_en_width", 32'(ew), 32'd2);
    checkOutput("data41_pulses", 32'(pulseWord.size()), 32'd1);
    checkOutput("data41_rs", 32'(lcdRs), 32'd1);
    checkOutput("data41_data", 32'(lcdData), 32'h41);
    checkOutput("data41_on", 32'(lcdOn), 32'd1);

    $display("[TB] long and short command timing");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].word, 1'b0, 32'h0, w, b, ef, ew);
      checkOutput($sformatf("busy_%0h", vecs[i].word), 32'(b), 32'(vecs[i].busy));
    end

    $display("[TB] valid held while busy, back-to-back accept");
    pulseWord.delete(); pulseAt.delete();
    applyStimulus(32'h8000_0243, 1'b1, 32'h8000_0244, w, b, ef, ew);
    checkOutput("hold_busy", 32'(b), 32'd7);
    applyStimulus(32'h8000_0244, 1'b0, 32'h0, w, b, ef, ew);
    checkOutput("b2b_wait", 32'(w), 32'd0);
    checkOutput("b2b_busy", 32'(b), 32'd7);
    checkOutput("hold_pulses", 32'(pulseWord.size()), 32'd2);
    if (pulseWord.size() >= 2) begin
      checkOutput("hold_word0", 32'(pulseWord[0]), 32'h143);
      checkOutput("hold_word1", 32'(pulseWord[1]), 32'h144);
    end

    $display("[TB] data write with ON cleared");
    applyStimulus(32'h0000_0248, 1'b0, 32'h0, w, b, ef, ew);
    checkOutput("off_busy", 32'(b), 32'd7);
    checkOutput("off_en_width", 32'(ew), 32'd2);
    checkOutput("off_on", 32'(lcdOn), 32'd0);
    checkOutput("off_rs", 32'(lcdRs), 32'd1);
    checkOutput("off_data", 32'(lcdData), 32'h48);

    $display("[TB] reset during enable pulse");
    t = 0;
    while (cmdReady !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    cmdWord = 32'h8000_0255; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    t = 0;
    while (lcdEn !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkOutput("en_before_reset", 32'(lcdEn), 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("rst_en", 32'(lcdEn), 32'd0);
    checkOutput("rst_ready", 32'(cmdReady), 32'd0);
    checkOutput("rst_done", 32'(initDone), 32'd0);
    checkOutput("rst_on", 32'(lcdOn), 32'd0);
    checkOutput("rst_rs", 32'(lcdRs), 32'd0);
    checkOutput("rst_data", 32'(lcdData), 32'd0);
    @(negedge clk);
    pulseWord.delete(); pulseAt.delete();
    rstN = 1'b1;
    waitInitDone("init2");
    checkInit("init2");

    applyStimulus(32'h8000_0230, 1'b0, 32'h0, w, b, ef, ew);
    checkOutput("post_reset_busy", 32'(b), 32'd7);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
